phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high, ports named as the codebase does (clk, reset).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 run  input  1  level; free-running execution request.
REQ-005 step  input  1  single-cycle pulse; execute exactly one instruction.
REQ-006 halt  input  1  HALT-instruction indication from decode.
REQ-007 clear  input  1  synchronous return to IDLE; clears the counter.
REQ-008 last_phase  input  3  index of the final phase of the current instruction (0..7).
REQ-009 num  output  3  current phase number; drives the 3-to-8 line decoder.
REQ-010 active  output  1  high while an instruction is executing.
REQ-011 halted  output  1  high in HALTED state.
REQ-012 instr_done  output  1  one-cycle pulse per completed instruction.
REQ-013 instr_count  output  8  completed-instruction counter.

Function
REQ-014 States SHALL be IDLE, RUN, STEP and HALTED; all outputs SHALL be registered.
REQ-015 In IDLE and HALTED, num SHALL be 0 and active SHALL be 0.
REQ-016 From IDLE: run=1 -> RUN next cycle; else step=1 -> STEP next cycle; run has priority over step.
REQ-017 In RUN/STEP: active=1; num SHALL increment by 1 each cycle while num < last_phase.
REQ-018 End phase: a cycle in RUN/STEP with num >= last_phase, including the case where last_phase is lowered below the current num mid-instruction.
REQ-019 On the cycle after an end phase, num SHALL be 0, instr_done SHALL be 1 for exactly that cycle, and instr_count SHALL increment modulo 256 (255 -> 0).
REQ-020 Next state at an end phase in RUN: halt=1 -> HALTED; else run=0 -> IDLE; else RUN, starting the next instruction at phase 0 with no gap cycle.
REQ-021 Next state at an end phase in STEP: halt=1 -> HALTED; else IDLE.
REQ-022 halt SHALL be sampled only at an end phase; run and step SHALL be ignored mid-instruction, so deasserting run completes the current instruction.
REQ-023 step pulses in RUN, STEP or HALTED SHALL be ignored.
REQ-024 With last_phase=0, every active cycle SHALL be an end phase; continuous RUN then gives num=0 constantly and instr_done=1 every cycle after the first.
REQ-025 HALTED SHALL be left only via clear or reset; halted=1 while in HALTED.
REQ-026 clear=1 SHALL, in any state, force IDLE on the next edge with num=0, instr_count=0 and instr_done=0; clear has priority over all other inputs.

Reset
REQ-027 Reset assertion SHALL immediately force IDLE, num=0, active=0, halted=0, instr_done=0 and instr_count=0, including mid-instruction.
REQ-028 After reset deasserts, the first transition SHALL be governed by REQ-016 on the first rising edge.

Verification
REQ-029 Scenario 1: reset, then run=1 with last_phase=3 -> num 0,1,2,3,0,1...; instr_done pulses when num returns to 0; instr_count 1,2...
REQ-030 Scenario 2: step pulse with last_phase=4 -> num 0..4, then IDLE; instr_done once; instr_count=1; active low afterwards.
REQ-031 Scenario 3: RUN with halt=1 at num=2 (last_phase=5) -> ignored; halt=1 at num=5 -> HALTED, halted=1, num=0; run and step then ignored until clear.
REQ-032 Scenario 4: last_phase=0 under run -> instr_done high every cycle; 256 instructions -> instr_count wraps to 0.
REQ-033 Scenario 5: last_phase lowered from 6 to 1 while num=3 -> that cycle is the end phase; next num=0, and instr_done=1.
REQ-034 Scenario 6: reset pulse at num=4 mid-RUN -> all outputs 0 immediately; clear in RUN -> IDLE and instr_count=0 on the next edge.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if
//   Bundles the sequencer's control inputs and status outputs.
//   master : driver of run/step/halt/clear/last_phase (decode/control side)
//   slave  : the sequencer itself
//   Signals:
//     run, step, halt, clear  - execution controls
//     last_phase[2:0]         - final phase index of the current instruction
//     num[2:0]                - current phase number
//     active, halted          - status levels
//     instr_done              - one-cycle pulse per completed instruction
//     instr_count[7:0]        - completed-instruction counter (wraps)
interface phase_sequencer_if;
  logic       run;
  logic       step;
  logic       halt;
  logic       clear;
  logic [2:0] last_phase;
  logic [2:0] num;
  logic       active;
  logic       halted;
  logic       instr_done;
  logic [7:0] instr_count;

  modport master (
    output run, step, halt, clear, last_phase,
    input  num, active, halted, instr_done, instr_count
  );

  modport slave (
    input  run, step, halt, clear, last_phase,
    output num, active, halted, instr_done, instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Steps an instruction through phases 0..last_phase, either free-running
//   (run) or one instruction at a time (step), and stops in HALTED when a
//   HALT instruction reaches its end phase. All outputs are registered.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-high reset
//     bus   - phase_sequencer_if.slave (controls in, phase/status out)
//
//   state  | meaning
//   IDLE   | waiting for run or step; num=0, active=0
//   RUN    | executing, continues into the next instruction while run=1
//   STEP   | executing exactly one instruction, then IDLE
//   HALTED | stopped by a HALT instruction; left only via clear/reset
module phase_sequencer (
  input logic              clk,
  input logic              reset,
  phase_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] STEP   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0] state;
  logic [2:0] num_q;
  logic       active_q;
  logic       halted_q;
  logic       done_q;
  logic [7:0] count_q;

  logic       end_phase;
  logic [1:0] end_state;

  // ">=" rather than "==" so lowering last_phase below the current phase
  // still terminates the instruction instead of running on to 7.
  assign end_phase = ((state == RUN) || (state == STEP)) && (num_q >= bus.last_phase);

  always_comb begin
    end_state = IDLE;
    if (bus.halt)
      end_state = HALTED;
    else if ((state == RUN) && bus.run)
      end_state = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      num_q    <= 3'd0;
      active_q <= 1'b0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 8'd0;
    end else if (bus.clear) begin
      state    <= IDLE;
      num_q    <= 3'd0;
      active_q <= 1'b0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          num_q  <= 3'd0;
          if (bus.run) begin
            state    <= RUN;
            active_q <= 1'b1;
          end else if (bus.step) begin
            state    <= STEP;
            active_q <= 1'b1;
          end
        end
        RUN, STEP: begin
          if (end_phase) begin
            num_q    <= 3'd0;
            done_q   <= 1'b1;
            count_q  <= count_q + 8'd1;
            state    <= end_state;
            active_q <= (end_state == RUN);
            halted_q <= (end_state == HALTED);
          end else begin
            num_q  <= num_q + 3'd1;
            done_q <= 1'b0;
          end
        end
        HALTED: begin
          done_q <= 1'b0;
          num_q  <= 3'd0;
        end
        default: begin
          state    <= IDLE;
          num_q    <= 3'd0;
          active_q <= 1'b0;
          halted_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.num         = num_q;
  assign bus.active      = active_q;
  assign bus.halted      = halted_q;
  assign bus.instr_done  = done_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
//   Directed scenarios followed by randomized control traffic, every cycle
//   compared against an abstract model of the sequencer's behaviour.
module tb_phase_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;

  phase_sequencer_if bus ();

  phase_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // abstract model: executing / free-running / stopped flags, phase, count
  int m_busy, m_free, m_stop, m_phase, m_cnt, m_pulse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_free = 0; m_stop = 0; m_phase = 0; m_cnt = 0; m_pulse = 0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit h, input bit c, input int lp);
    if (c) begin
      model_reset();
    end else if (m_stop != 0) begin
      m_pulse = 0;
    end else if (m_busy == 0) begin
      m_pulse = 0;
      if (r) begin m_busy = 1; m_free = 1; end
      else if (s) begin m_busy = 1; m_free = 0; end
    end else if (m_phase >= lp) begin
      m_pulse = 1;
      m_cnt   = (m_cnt + 1) % 256;
      m_phase = 0;
      if (h) begin m_busy = 0; m_stop = 1; end
      else if (m_free == 0 || !r) m_busy = 0;
    end else begin
      m_phase = m_phase + 1;
      m_pulse = 0;
    end
  endtask

  task automatic check_all(input string where);
    chk({where, " num"},         bus.num,         m_phase);
    chk({where, " active"},      bus.active,      m_busy);
    chk({where, " halted"},      bus.halted,      m_stop);
    chk({where, " instr_done"},  bus.instr_done,  m_pulse);
    chk({where, " instr_count"}, bus.instr_count, m_cnt);
  endtask

  task automatic cycle(input bit r, input bit s, input bit h, input bit c, input int lp, input string where);
    bus.run = r; bus.step = s; bus.halt = h; bus.clear = c; bus.last_phase = 3'(lp);
    @(posedge clk);
    model_edge(r, s, h, c, lp);
    #1;
    check_all(where);
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    reset = 1'b0;
  endtask

  initial begin
    bus.run = 0; bus.step = 0; bus.halt = 0; bus.clear = 0; bus.last_phase = 3'd0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Scenario 1: free run, last_phase=3
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 3, "s1_run");

    // Scenario 2: single step, last_phase=4
    cycle(0, 0, 0, 1, 4, "s2_clear");
    cycle(0, 1, 0, 0, 4, "s2_step");
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 4, "s2_exec");
    chk("s2 count", bus.instr_count, 1);
    chk("s2 active", bus.active, 0);

    // Scenario 3: halt mid-instruction ignored, at end phase honoured
    cycle(0, 0, 0, 1, 5, "s3_clear");
    for (int i = 0; i < 14 && m_stop == 0; i++)
      cycle(1, 0, (m_busy != 0 && (m_phase == 2 || m_phase == 5)), 0, 5, "s3_run");
    chk("s3 halted", bus.halted, 1);
    for (int i = 0; i < 5; i++) cycle(1, i[0], 0, 0, 5, "s3_ignored");
    cycle(0, 0, 0, 1, 5, "s3_clear_out");

    // Scenario 4: last_phase=0, 256 instructions wrap the counter
    for (int i = 0; i < 257; i++) cycle(1, 0, 0, 0, 0, "s4_wrap");
    chk("s4 count wrap", bus.instr_count, 0);
    chk("s4 done", bus.instr_done, 1);

    // Scenario 5: last_phase lowered from 6 to 1 at num=3
    cycle(0, 0, 0, 1, 6, "s5_clear");
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, (m_busy != 0 && m_phase == 3) ? 1 : 6, "s5_lower");

    // Scenario 6: async reset at num=4, then clear while running
    for (int i = 0; i < 20 && !(m_busy != 0 && m_phase == 4); i++) cycle(1, 0, 0, 0, 6, "s6_run");
    mid_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 2, "s6_rerun");
    cycle(1, 0, 0, 1, 2, "s6_clear");
    chk("s6 clear count", bus.instr_count, 0);

    // randomized traffic
    begin
      int lp = 3;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) lp = $urandom_range(0, 7);
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, lp, "rand");
        if ($urandom_range(0, 499) == 0) mid_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
